// File: rtl/isolde_pkg.sv
`default_nettype none
// isolde_pkg: ISOLDE ISA definitions shared across the core (opcode encoding, vector register file width).
// rev 1.0
package isolde_pkg;

  localparam int RegAddrWidth = 5;

  // Encodings 3'd4..3'd7 are reserved; the scheduler treats them as illegal.
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_GEMM    = 3'd1,
    OP_CONV2D  = 3'd2,
    OP_VLE32_4 = 3'd3
  } isolde_opcode_e;

endpackage
`default_nettype wire

// File: rtl/isolde_sched_pkg.sv
`default_nettype none
// isolde_sched_pkg: lane/state enums, queue entry type and operand-decode helpers for the execution scheduler.
// rev 1.0
package isolde_sched_pkg;
  import isolde_pkg::*;

  localparam int NumRegs  = 2 ** RegAddrWidth;
  localparam int NumLanes = 2;
  localparam int LaneMat  = 0;
  localparam int LaneLd   = 1;
  localparam int LatWidth = 3;

  typedef enum logic [1:0] {
    LANE_NONE = 2'd0,
    LANE_MAT  = 2'd1,
    LANE_LD   = 2'd2,
    LANE_BAD  = 2'd3
  } lane_e;

  typedef enum logic {
    LS_IDLE   = 1'b0,
    LS_ACTIVE = 1'b1
  } lane_state_e;

  typedef struct packed {
    isolde_opcode_e          opcode;
    logic [RegAddrWidth-1:0] rd;
    logic [RegAddrWidth-1:0] rs1;
    logic [RegAddrWidth-1:0] rs2;
  } sched_entry_t;

  function automatic lane_e lane_of(isolde_opcode_e op);
    lane_e lane;
    case (op)
      OP_NOP:              lane = LANE_NONE;
      OP_GEMM, OP_CONV2D:  lane = LANE_MAT;
      OP_VLE32_4:          lane = LANE_LD;
      default:             lane = LANE_BAD;
    endcase
    return lane;
  endfunction

  // One-hot set of registers an entry reads or writes; drives both RAW and WAW checks.
  function automatic logic [NumRegs-1:0] used_regs(sched_entry_t e);
    logic [NumRegs-1:0] mask;
    mask = '0;
    case (e.opcode)
      OP_GEMM: begin
        mask[e.rd]  = 1'b1;
        mask[e.rs1] = 1'b1;
        mask[e.rs2] = 1'b1;
      end
      OP_CONV2D, OP_VLE32_4: mask[e.rd] = 1'b1;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/isolde_sched_fifo.sv
`default_nettype none
// isolde_sched_fifo: in-order issue queue, power-of-two depth, generic entry type, async active-low reset.
// rev 1.0
module isolde_sched_fifo #(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = logic [7:0]
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  logic   pop_i,
  input  ENTRY_T wdata_i,
  output ENTRY_T rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PtrW = $clog2(DEPTH);

  ENTRY_T          mem [DEPTH];
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic [PtrW:0]   count;
  logic            do_push;
  logic            do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = (count == (PtrW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign rdata_o = mem[rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked solely by count.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wptr] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/isolde_exec_sched.sv
`default_nettype none
// isolde_exec_sched: in-order issue queue feeding a matrix lane and a load lane with a register scoreboard.
// rev 1.0
module isolde_exec_sched
  import isolde_pkg::*;
  import isolde_sched_pkg::*;
#(
  parameter int QueueDepth = 4,
  parameter int MatLatency = 4,
  parameter int LdLatency  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dec_valid_i,
  output logic                    dec_ready_o,
  input  isolde_opcode_e          dec_opcode_i,
  input  logic [RegAddrWidth-1:0] dec_rd_i,
  input  logic [RegAddrWidth-1:0] dec_rs1_i,
  input  logic [RegAddrWidth-1:0] dec_rs2_i,
  output logic                    mat_start_o,
  output isolde_opcode_e          mat_opcode_o,
  output logic                    ld_start_o,
  output logic [RegAddrWidth-1:0] issue_rd_o,
  output logic [RegAddrWidth-1:0] issue_rs1_o,
  output logic [RegAddrWidth-1:0] issue_rs2_o,
  output logic                    mat_done_o,
  output logic                    ld_done_o,
  output logic                    illegal_o,
  output logic                    busy_o
);

  sched_entry_t            push_entry;
  sched_entry_t            head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    ready_en;
  lane_e                   head_lane;
  logic                    head_hazard;
  logic [NumRegs-1:0]      pending;
  logic [NumRegs-1:0]      pending_set;
  logic [NumRegs-1:0]      pending_clr;
  logic [NumLanes-1:0]     lane_idle;
  logic [NumLanes-1:0]     lane_start;
  logic [NumLanes-1:0]     lane_done;
  logic [RegAddrWidth-1:0] lane_rd [NumLanes];

  // Ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign dec_ready_o = ready_en && !fifo_full;
  assign push        = dec_valid_i && dec_ready_o;
  assign push_entry  = '{opcode: dec_opcode_i, rd: dec_rd_i, rs1: dec_rs1_i, rs2: dec_rs2_i};

  isolde_sched_fifo #(
    .DEPTH   (QueueDepth),
    .ENTRY_T (sched_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head-of-queue issue decision; a blocked head stalls everything behind it.
  always_comb begin
    head_lane   = lane_of(head.opcode);
    head_hazard = |(used_regs(head) & pending);
    lane_start  = '0;
    pop         = 1'b0;
    illegal_o   = 1'b0;
    if (!fifo_empty) begin
      case (head_lane)
        LANE_NONE: pop = 1'b1;
        LANE_BAD: begin
          pop       = 1'b1;
          illegal_o = 1'b1;
        end
        LANE_MAT: begin
          if (lane_idle[LaneMat] && !head_hazard) begin
            pop                 = 1'b1;
            lane_start[LaneMat] = 1'b1;
          end
        end
        LANE_LD: begin
          if (lane_idle[LaneLd] && !head_hazard) begin
            pop                = 1'b1;
            lane_start[LaneLd] = 1'b1;
          end
        end
        default: pop = 1'b0;
      endcase
    end
  end

  assign mat_start_o  = lane_start[LaneMat];
  assign ld_start_o   = lane_start[LaneLd];
  assign mat_opcode_o = lane_start[LaneMat] ? head.opcode : OP_NOP;
  assign issue_rd_o   = (|lane_start) ? head.rd  : '0;
  assign issue_rs1_o  = (|lane_start) ? head.rs1 : '0;
  assign issue_rs2_o  = (|lane_start) ? head.rs2 : '0;
  assign mat_done_o   = lane_done[LaneMat];
  assign ld_done_o    = lane_done[LaneLd];
  assign busy_o       = !fifo_empty || !(&lane_idle);

  // Scoreboard: a set and a clear never target the same bit in one cycle because
  // a pending destination blocks issue until it is released.
  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    for (int l = 0; l < NumLanes; l++) begin
      if (lane_start[l]) begin
        pending_set[head.rd] = 1'b1;
      end
      if (lane_done[l]) begin
        pending_clr[lane_rd[l]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~pending_clr) | pending_set;
    end
  end

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    localparam logic [LatWidth-1:0] Lat =
      (l == LaneMat) ? LatWidth'(MatLatency) : LatWidth'(LdLatency);

    lane_state_e             state;
    lane_state_e             state_next;
    logic [LatWidth-1:0]     cnt;
    logic [LatWidth-1:0]     cnt_next;
    logic [RegAddrWidth-1:0] rd_q;
    logic                    done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state <= LS_IDLE;
        cnt   <= '0;
        rd_q  <= '0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
        if (lane_start[l]) begin
          rd_q <= head.rd;
        end
      end
    end

    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      done       = 1'b0;
      case (state)
        LS_IDLE: begin
          if (lane_start[l]) begin
            state_next = LS_ACTIVE;
            cnt_next   = LatWidth'(1);
          end
        end
        LS_ACTIVE: begin
          if (cnt == Lat) begin
            done       = 1'b1;
            state_next = LS_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = LS_IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    assign lane_idle[l] = (state == LS_IDLE);
    assign lane_done[l] = done;
    assign lane_rd[l]   = rd_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_isolde_exec_sched.sv
`default_nettype none
// tb_isolde_exec_sched: vector table, corner sequences and a randomized run against a timestamp-based model.
// rev 1.0
module tb_isolde_exec_sched;
  import isolde_pkg::*;

  localparam int QD = 4;
  localparam int ML = 4;
  localparam int LL = 2;
  localparam int RW = RegAddrWidth;
  localparam int NR = 2 ** RegAddrWidth;
  localparam int NOP = int'(OP_NOP);
  localparam int GEMM = int'(OP_GEMM);
  localparam int CONV = int'(OP_CONV2D);
  localparam int VLE = int'(OP_VLE32_4);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dec_valid = 1'b0;
  logic dec_ready;
  isolde_opcode_e dec_opcode = OP_NOP;
  logic [RW-1:0] dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
  logic mat_start, ld_start, mat_done, ld_done, illegal, busy;
  isolde_opcode_e mat_opcode;
  logic [RW-1:0] issue_rd, issue_rs1, issue_rs2;

  isolde_exec_sched #(.QueueDepth(QD), .MatLatency(ML), .LdLatency(LL)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready), .dec_opcode_i(dec_opcode),
    .dec_rd_i(dec_rd), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .mat_start_o(mat_start), .mat_opcode_o(mat_opcode), .ld_start_o(ld_start),
    .issue_rd_o(issue_rd), .issue_rs1_o(issue_rs1), .issue_rs2_o(issue_rs2),
    .mat_done_o(mat_done), .ld_done_o(ld_done), .illegal_o(illegal), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: queue of instructions plus per-lane done cycle and per-register free cycle.
  typedef struct { int op; int rd; int rs1; int rs2; } ins_t;
  ins_t q[$];
  int cyc = 0;
  int lane_done_at[2] = '{-1, -1};
  int reg_free_at[NR];
  bit ready_en = 1'b0;

  logic s_ready, s_ms, s_ls, s_md, s_ld, s_ill, s_busy;
  int s_op, s_rd, s_rs1, s_rs2;

  task automatic tick();
    bit e_ready, e_ms, e_ls, e_md, e_ld, e_ill, e_busy, pop, hazard;
    logic [2:0] e_op;
    logic [RW-1:0] e_rd, e_rs1, e_rs2;
    logic [9+3*RW:0] expv, actv;
    int lane, lat;
    ins_t h;
    @(negedge clk);
    s_ready = dec_ready; s_ms = mat_start; s_ls = ld_start; s_md = mat_done; s_ld = ld_done;
    s_ill = illegal; s_busy = busy; s_op = int'(mat_opcode);
    s_rd = int'(issue_rd); s_rs1 = int'(issue_rs1); s_rs2 = int'(issue_rs2);
    {e_ready, e_ms, e_ls, e_md, e_ld, e_ill, e_busy, pop} = '0;
    e_op = '0; e_rd = '0; e_rs1 = '0; e_rs2 = '0;
    if (rst_n) begin
      e_ready = ready_en && (q.size() < QD);
      e_md = (lane_done_at[0] == cyc);
      e_ld = (lane_done_at[1] == cyc);
      e_busy = (q.size() > 0) || (lane_done_at[0] >= cyc) || (lane_done_at[1] >= cyc);
      if (q.size() > 0) begin
        h = q[0];
        if (h.op == NOP) begin
          pop = 1'b1;
        end else if (h.op == GEMM || h.op == CONV || h.op == VLE) begin
          lane = (h.op == VLE) ? 1 : 0;
          lat = (h.op == VLE) ? LL : ML;
          hazard = (reg_free_at[h.rd] > cyc) ||
                   (h.op == GEMM && (reg_free_at[h.rs1] > cyc || reg_free_at[h.rs2] > cyc));
          if (lane_done_at[lane] < cyc && !hazard) begin
            pop = 1'b1;
            if (lane == 0) begin e_ms = 1'b1; e_op = 3'(h.op); end
            else e_ls = 1'b1;
            e_rd = RW'(h.rd); e_rs1 = RW'(h.rs1); e_rs2 = RW'(h.rs2);
            lane_done_at[lane] = cyc + lat;
            reg_free_at[h.rd] = cyc + lat + 1;
          end
        end else begin
          pop = 1'b1;
          e_ill = 1'b1;
        end
      end
      if (pop) void'(q.pop_front());
      if (dec_valid && e_ready)
        q.push_back('{int'(dec_opcode), int'(dec_rd), int'(dec_rs1), int'(dec_rs2)});
      ready_en = 1'b1;
    end else begin
      q.delete();
      ready_en = 1'b0;
      lane_done_at = '{-1, -1};
      foreach (reg_free_at[i]) reg_free_at[i] = 0;
    end
    expv = {e_ready, e_ms, e_ls, e_md, e_ld, e_ill, e_busy, e_op, e_rd, e_rs1, e_rs2};
    actv = {dec_ready, mat_start, ld_start, mat_done, ld_done, illegal, busy,
            mat_opcode, issue_rd, issue_rs1, issue_rs2};
    total++;
    if (actv !== expv) begin
      bad++;
      $display("FAIL model cycle %0d: got %h expected %h", cyc, actv, expv);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int op, int rd = 0, int rs1 = 0, int rs2 = 0);
    logic [2:0] opb;
    opb = 3'(op);
    dec_valid = v;
    dec_opcode = isolde_opcode_e'(opb);
    dec_rd = RW'(rd); dec_rs1 = RW'(rs1); dec_rs2 = RW'(rs2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(0, NOP);
    do begin
      tick();
      n++;
    end while (s_busy && n < 100);
    if (n >= 100) chk("drain_timeout", 1, 0);
  endtask

  typedef struct { int op; int rd; int rs1; int rs2; bit ms; bit ls; bit ill; int lat; } vec_t;
  vec_t vt[6];

  initial begin
    int acc, drop_c, rec_c, first_pop, n, md_cnt, r;
    foreach (reg_free_at[i]) reg_free_at[i] = 0;
    vt[0] = '{GEMM, 3, 1, 2, 1'b1, 1'b0, 1'b0, ML};
    vt[1] = '{CONV, 7, 4, 5, 1'b1, 1'b0, 1'b0, ML};
    vt[2] = '{VLE, 9, 0, 0, 1'b0, 1'b1, 1'b0, LL};
    vt[3] = '{NOP, 1, 1, 1, 1'b0, 1'b0, 1'b0, 0};
    vt[4] = '{5, 2, 3, 4, 1'b0, 1'b0, 1'b1, 0};
    vt[5] = '{GEMM, 31, 30, 0, 1'b1, 1'b0, 1'b0, ML};

    // Reset state
    drive(1, GEMM, 1, 2, 3);
    repeat (3) tick();
    chk("reset_ready", s_ready, 0);
    chk("reset_busy", s_busy, 0);
    chk("reset_start", s_ms, 0);
    rst_n = 1'b1;
    drive(0, NOP);
    tick();
    tick();
    chk("ready_after_release", s_ready, 1);

    // Single-instruction vectors: accept, issue next cycle, retire after latency
    for (int i = 0; i < 6; i++) begin
      drive(1, vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2);
      tick();
      drive(0, NOP);
      tick();
      chk($sformatf("vec%0d_mat_start", i), s_ms, vt[i].ms);
      chk($sformatf("vec%0d_ld_start", i), s_ls, vt[i].ls);
      chk($sformatf("vec%0d_illegal", i), s_ill, vt[i].ill);
      chk($sformatf("vec%0d_mat_opcode", i), s_op, vt[i].ms ? vt[i].op : 0);
      chk($sformatf("vec%0d_issue_rd", i), s_rd, (vt[i].ms || vt[i].ls) ? vt[i].rd : 0);
      chk($sformatf("vec%0d_issue_rs1", i), s_rs1, (vt[i].ms || vt[i].ls) ? vt[i].rs1 : 0);
      if (vt[i].lat > 0) begin
        repeat (vt[i].lat - 1) tick();
        chk($sformatf("vec%0d_done_early", i), vt[i].ms ? s_md : s_ld, 0);
        tick();
        chk($sformatf("vec%0d_done", i), vt[i].ms ? s_md : s_ld, 1);
      end
      drain();
    end

    // gemm retire timing and idle afterwards
    drive(1, GEMM, 3, 1, 2); tick();
    drive(0, NOP); tick();
    chk("gemm_start_c1", s_ms, 1);
    chk("gemm_rd_c1", s_rd, 3);
    repeat (3) tick();
    tick();
    chk("gemm_done_c5", s_md, 1);
    tick();
    chk("gemm_idle_c6", s_busy, 0);
    drain();

    // RAW: gemm reads the load's destination
    drive(1, VLE, 1); tick();
    drive(1, GEMM, 6, 1, 7); tick();
    chk("raw_ld_start_c1", s_ls, 1);
    drive(0, NOP); tick();
    chk("raw_blocked_c2", s_ms, 0);
    tick();
    chk("raw_ld_done_c3", s_ld, 1);
    chk("raw_blocked_c3", s_ms, 0);
    tick();
    chk("raw_mat_start_c4", s_ms, 1);
    drain();

    // Independent lanes back to back
    drive(1, GEMM, 4, 2, 3); tick();
    drive(1, VLE, 5); tick();
    chk("indep_mat_c1", s_ms, 1);
    drive(0, NOP); tick();
    chk("indep_ld_c2", s_ls, 1);
    drain();

    // Fill the queue behind a busy matrix lane
    drive(1, GEMM, 9, 9, 9); tick();
    acc = 0; drop_c = -1; rec_c = -1; first_pop = -1; n = 0;
    while (acc < 6 && n < 40) begin
      drive(1, CONV, 16 + acc);
      tick();
      n++;
      if (s_ms && n > 1 && first_pop < 0) first_pop = n;
      if (s_ready) begin
        if (drop_c >= 0 && rec_c < 0) rec_c = n;
        acc++;
      end else if (drop_c < 0) begin
        drop_c = n;
        chk("fill_accepts_before_full", acc, QD);
      end
    end
    chk("fill_all_accepted", acc, 6);
    chk("ready_recovers_after_pop", rec_c, first_pop + 1);
    drain();

    // Illegal opcode, nop, then load
    drive(1, 5, 1, 1, 1); tick();
    drive(1, NOP); tick();
    chk("illegal_pulse", s_ill, 1);
    drive(1, VLE, 12); tick();
    chk("nop_no_illegal", s_ill, 0);
    chk("nop_no_start", s_ms | s_ls, 0);
    drive(0, NOP); tick();
    chk("ld_after_illegal", s_ls, 1);
    drain();

    // Reset in the middle of a gemm
    drive(1, GEMM, 3, 1, 2); tick();
    drive(0, NOP); tick();
    chk("rst_gemm_start", s_ms, 1);
    rst_n = 1'b0;
    tick();
    chk("rst_busy_low", s_busy, 0);
    tick();
    rst_n = 1'b1;
    md_cnt = 0;
    repeat (8) begin
      tick();
      md_cnt += int'(s_md);
    end
    chk("rst_no_done", md_cnt, 0);
    drive(1, GEMM, 3, 1, 2); tick();
    drive(0, NOP); tick();
    chk("rst_reissue_start", s_ms, 1);
    chk("rst_reissue_rd", s_rd, 3);
    drain();

    // Randomized traffic against the model, with occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        drive(0, NOP);
        tick();
        rst_n = 1'b1;
      end
      r = $urandom_range(0, 9);
      drive($urandom_range(0, 9) < 6,
            (r < 3) ? GEMM : (r < 5) ? CONV : (r < 7) ? VLE : (r < 8) ? NOP : 4 + (r - 8) * 3,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/isolde_exec_sched.md
ISOLDE_EXEC_SCHED -- requirements
Module: isolde_exec_sched

Interface
REQ-001 Parameter QueueDepth, default 4: issue-queue entries (power of two, >=2).
REQ-002 Parameter MatLatency, default 4: cycles from matrix-lane start to done (1..7).
REQ-003 Parameter LdLatency, default 2: cycles from load-lane start to done (1..7).
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 dec_valid_i  in  1  decoder offers an instruction.
REQ-007 dec_ready_o  out  1  scheduler accepts; transfer when valid and ready both high.
REQ-008 dec_opcode_i  in  isolde_opcode_e  decoded opcode.
REQ-009 dec_rd_i / dec_rs1_i / dec_rs2_i  in  RegAddrWidth each  ISOLDE vector register addresses.
REQ-010 mat_start_o  out  1  one-cycle start pulse to the matrix lane (gemm, conv2d).
REQ-011 mat_opcode_o  out  isolde_opcode_e  opcode for the matrix lane, valid with mat_start_o.
REQ-012 ld_start_o  out  1  one-cycle start pulse to the load lane (vle32_4).
REQ-013 issue_rd_o / issue_rs1_o / issue_rs2_o  out  RegAddrWidth  operands of the entry issued this cycle.
REQ-014 mat_done_o / ld_done_o  out  1  one-cycle retire pulse per lane.
REQ-015 illegal_o  out  1  one-cycle pulse when an unknown opcode is dropped.
REQ-016 busy_o  out  1  high while the queue is non-empty or either lane is active.

Function
REQ-017 Accepted instructions SHALL enter an in-order FIFO; dec_ready_o = (count < QueueDepth), independent of same-cycle pop.
REQ-018 An accepted entry SHALL be issuable no earlier than the cycle after acceptance; no bypass.
REQ-019 Operand use SHALL derive from opcode: gemm uses rd, rs1, rs2; conv2d and vle32_4 use rd only; nop uses none.
REQ-020 A 2^RegAddrWidth-bit pending scoreboard SHALL set bit rd on lane start and clear it on that lane's done pulse.
REQ-021 The queue head SHALL issue only when its lane is IDLE and none of its used registers is pending (RAW and WAW check).
REQ-022 A pending bit cleared in cycle t SHALL unblock the head no earlier than cycle t+1.
REQ-023 Issue SHALL be strictly in order; a blocked head blocks all younger entries, including entries for the other lane.
REQ-024 Each lane SHALL run FSM IDLE -> ACTIVE on start, with a counter loaded with 1; ACTIVE -> IDLE when the counter equals the lane latency.
REQ-025 Start in cycle t SHALL produce done in cycle t+Latency; a lane SHALL accept a new start in the cycle after done.
REQ-026 nop at the head SHALL pop in one cycle with no start or done pulse and no scoreboard change.
REQ-027 An unknown opcode at the head SHALL pop in one cycle, pulse illegal_o and start no lane.
REQ-028 At most one entry SHALL pop per cycle; matrix and load lanes SHALL run concurrently, and done pulses may coincide.
REQ-029 issue_* outputs SHALL be zero when no start pulse is asserted.
REQ-030 busy_o SHALL be combinational from queue count and lane states.

Reset
REQ-031 Asserting rst_ni low SHALL immediately empty the queue, clear the scoreboard, force both lanes to IDLE and zero the counters.
REQ-032 During reset, every pulse output, issue_* and busy_o SHALL be 0, and dec_ready_o SHALL be 0.
REQ-033 An in-flight operation interrupted by reset SHALL produce no done pulse after reset release.
REQ-034 dec_ready_o SHALL be 1 from the first clock edge after reset release.

Structure
REQ-035 Package isolde_sched_pkg SHALL hold the lane enum, the queue-entry struct (opcode, rd, rs1, rs2) and the lane FSM state enum; isolde_opcode_e and RegAddrWidth SHALL come from the existing packages.
REQ-036 The FIFO SHALL be a sub-module isolde_sched_fifo, parameterised by depth and entry type, exposing full, empty, push and pop signals.

Verification
REQ-037 Accept gemm rd=3 rs1=1 rs2=2 at cycle 0 -> mat_start_o at cycle 1 with issue_rd_o=3, mat_done_o at cycle 5, busy_o low at cycle 6.
REQ-038 Accept vle32_4 rd=1 at cycle 0, then gemm rs1=1 at cycle 1 -> ld_start_o at cycle 1, ld_done_o at cycle 3, mat_start_o at cycle 4.
REQ-039 Accept gemm rd=4, then vle32_4 rd=5 on consecutive cycles -> mat_start_o at cycle 1 and ld_start_o at cycle 2 (independent lanes).
REQ-040 Hold dec_valid_i high with 6 conv2d entries while the matrix lane is busy -> dec_ready_o drops after 4 accepts and recovers on the first pop.
REQ-041 Enqueue an unknown opcode, then nop, then vle32_4 -> illegal_o pulses, the nop produces no pulse, and ld_start_o follows two cycles after illegal_o.
REQ-042 Assert rst_ni low at cycle 2 of a gemm -> no mat_done_o occurs, the scoreboard is clear, and the same rd issues immediately after re-accept.
